// File: rtl/ads5404_sync_ctrl.sv
// ads5404_sync_ctrl: power-up / resync sequencer for one ADS5404 capture interface.
// Sequence: reset ADC+PLL, wait for PLL lock, enable, SYNC pulse, confirm the SYNCOUT
// echo, then hold RUN while watching lock. Failed attempts retry up to MAX_RETRY times.
module ads5404_sync_ctrl #(
    parameter int CNT_W        = 16,
    parameter int RST_CYCLES   = 1000,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int SETTLE_CYC   = 256,
    parameter int SYNC_CYCLES  = 16,
    parameter int ECHO_TIMEOUT = 1024,
    parameter int MAX_RETRY    = 3,
    localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pll_locked,
    input  logic             syncout_0,
    input  logic             syncout_1,
    output logic             user_rst,
    output logic             user_enable,
    output logic             user_sync,
    output logic             ready,
    output logic             error,
    output logic [2:0]       state,
    output logic [RW-1:0]    retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LOCK = 3'd2,
        ENABLE    = 3'd3,
        SYNC      = 3'd4,
        WAIT_ECHO = 3'd5,
        RUN       = 3'd6,
        FAIL      = 3'd7
    } state_t;

    // Terminal timer values: timer starts at 0 on entry, so a state lasts N cycles
    // when it leaves on timer == N-1.
    localparam logic [CNT_W-1:0] T_RST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] T_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] T_SYNC   = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_ECHO   = CNT_W'(ECHO_TIMEOUT - 1);

    state_t             st, st_nxt;
    logic [CNT_W-1:0]   timer;
    logic [RW-1:0]      retry_nxt;
    logic [CNT_W-1:0]   loss_nxt;
    logic [1:0]         lock_ff, s0_ff, s1_ff;
    logic               lock_prev, echo_prev;
    logic               lock_s, echo, lock_fall, echo_rise, do_retry;

    assign lock_s    = lock_ff[1];
    assign echo      = s0_ff[1] | s1_ff[1];
    assign lock_fall = lock_prev & ~lock_s;
    assign echo_rise = echo & ~echo_prev;
    assign state     = st;

    // Two-flop synchronisers for the async status inputs plus edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_ff   <= '0;
            s0_ff     <= '0;
            s1_ff     <= '0;
            lock_prev <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            lock_ff   <= {lock_ff[0], pll_locked};
            s0_ff     <= {s0_ff[0], syncout_0};
            s1_ff     <= {s1_ff[0], syncout_1};
            lock_prev <= lock_s;
            echo_prev <= echo;
        end
    end

    // Next state and counter updates; abort > lock loss/timeout > start > advance.
    always_comb begin
        st_nxt    = st;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        do_retry  = 1'b0;
        if (abort) begin
            st_nxt = IDLE;
        end else begin
            case (st)
                IDLE, FAIL: if (start) begin
                    st_nxt    = RESET;
                    retry_nxt = '0;
                    loss_nxt  = '0;
                end
                RESET:      if (timer == T_RST) st_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (timer == T_LOCK) do_retry = 1'b1;
                    else if (lock_s)     st_nxt   = ENABLE;
                end
                ENABLE: begin
                    if (!lock_s)                do_retry = 1'b1;
                    else if (timer == T_SETTLE) st_nxt   = SYNC;
                end
                SYNC:       if (timer == T_SYNC) st_nxt = WAIT_ECHO;
                WAIT_ECHO: begin
                    if (timer == T_ECHO) do_retry = 1'b1;
                    else if (echo_rise)  st_nxt   = RUN;
                end
                RUN: begin
                    if (lock_fall) begin
                        st_nxt    = RESET;
                        retry_nxt = '0;
                        if (lock_loss_cnt != '1) loss_nxt = lock_loss_cnt + 1'b1;
                    end else if (start) begin
                        st_nxt    = RESET;
                        retry_nxt = '0;
                        loss_nxt  = '0;
                    end
                end
                default:    st_nxt = IDLE;
            endcase
            // The failed attempt that would push the count past MAX_RETRY ends in FAIL,
            // leaving the count saturated at MAX_RETRY.
            if (do_retry) begin
                if (retry_cnt >= RW'(MAX_RETRY)) begin
                    st_nxt = FAIL;
                end else begin
                    retry_nxt = retry_cnt + 1'b1;
                    st_nxt    = RESET;
                end
            end
        end
    end

    // State, timer, counters and registered outputs decoded from the next state so
    // outputs line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            user_rst      <= 1'b1;
            user_enable   <= 1'b0;
            user_sync     <= 1'b0;
            ready         <= 1'b0;
            error         <= 1'b0;
        end else begin
            st            <= st_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            if (st_nxt != st)     timer <= '0;
            else if (timer != '1) timer <= timer + 1'b1;
            user_rst    <= (st_nxt == IDLE) || (st_nxt == RESET) || (st_nxt == FAIL);
            user_enable <= (st_nxt == ENABLE) || (st_nxt == SYNC) ||
                           (st_nxt == WAIT_ECHO) || (st_nxt == RUN);
            user_sync   <= (st_nxt == SYNC);
            ready       <= (st_nxt == RUN);
            error       <= (st_nxt == FAIL);
        end
    end

endmodule
